// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide/remainder sequencer.
// Shift-add multiply and restoring divide on operand magnitudes, with sign
// fix-up applied once at the end. Optional MUL_ZERO_SKIP_EN short-circuits
// multiplies that have a zero operand.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [2:0]       funct3_i,
   input  logic [WIDTH-1:0] rs1_data_i,
   input  logic [WIDTH-1:0] rs2_data_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             stall_o
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic               s1_q, s1_d;
   logic               s2_q, s2_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   // Next-state, iteration step and sign fix-up
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      a_d      = a_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;

      a_neg    = s1_q & a_q[WIDTH-1];
      b_neg    = s2_q & b_q[WIDTH-1];
      mag_a    = a_neg ? -a_q : a_q;
      mag_b    = b_neg ? -b_q : b_q;
      // a_q holds the multiplicand / divisor magnitude while iterating
      add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
      shifted  = {hi_q, lo_q[WIDTH-1]};
      trial    = shifted - {1'b0, a_q};
      prod     = {hi_q, lo_q};
      prod_fix = neg_q ? -prod : prod;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               op_d    = funct3_i;
               a_d     = rs1_data_i;
               b_d     = rs2_data_i;
               s1_d    = !(funct3_i == 3'b011 || funct3_i == 3'b101 || funct3_i == 3'b111);
               s2_d    = (funct3_i == 3'b000 || funct3_i == 3'b001 ||
                          funct3_i == 3'b100 || funct3_i == 3'b110);
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            cnt_d  = CW'(WIDTH);
            hi_d   = '0;
            if (op_q[2]) begin
               a_d  = mag_b;
               lo_d = mag_a;
            end else begin
               a_d  = mag_a;
               lo_d = mag_b;
            end
            if (op_q[2] && b_q == '0) begin
               result_d = op_q[1] ? a_q : '1;
               state_d  = S_DONE;
            end
`ifdef MUL_ZERO_SKIP_EN
            else if (!op_q[2] && (a_q == '0 || b_q == '0)) begin
               result_d = '0;
               state_d  = S_DONE;
            end
`endif
            else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (!op_q[2]) begin
               {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
            end else if (!trial[WIDTH]) begin
               hi_d = trial[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = shifted[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == CW'(1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (op_q[2]) begin
               if (op_q[1]) begin
                  result_d = rneg_q ? -hi_q : hi_q;
               end else begin
                  result_d = neg_q ? -lo_q : lo_q;
               end
            end else if (op_q[1:0] == 2'b00) begin
               result_d = prod_fix[WIDTH-1:0];
            end else begin
               result_d = prod_fix[2*WIDTH-1:WIDTH];
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy_o   = (state_q != S_IDLE);
   assign done_o   = (state_q == S_DONE);
   assign result_o = result_q;
   assign stall_o  = start_i & ~done_o;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (WIDTH=32). Latencies are counted
// in clock edges including the accept edge. Build with +define+MUL_ZERO_SKIP_EN
// to exercise the zero-operand multiply shortcut.
module tb_muldiv_sequencer;

   localparam int LAT_FULL = 35;
   localparam int LAT_DZ   = 2;
`ifdef MUL_ZERO_SKIP_EN
   localparam int LAT_MZ   = 2;
`else
   localparam int LAT_MZ   = 35;
`endif

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
      bit          drop;
      bit          keep;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  funct3_i = '0;
   logic [31:0] rs1_data_i = '0;
   logic [31:0] rs2_data_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic        stall_o;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q[$];

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_i    (start_i),
      .funct3_i   (funct3_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o),
      .stall_o    (stall_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub, p;
      logic [63:0] up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'b0, b};
      case (f)
         3'b000: begin p = sa * sb; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            return $signed(a) / $signed(b);
         end
         3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && b == 0) return LAT_DZ;
      if (!f[2] && (a == 0 || b == 0)) return LAT_MZ;
      return LAT_FULL;
   endfunction

   // Issue one op at a negedge, return at the negedge after the done pulse ends.
   task automatic run_op(input vec_t v, input string nm);
      int edges;
      int guard;
      bit stall_ok;
      logic [31:0] exp;
      funct3_i   = v.f;
      rs1_data_i = v.a;
      rs2_data_i = v.b;
      start_i    = 1'b1;
      sb_q.push_back(v.res);
      edges = 0;
      guard = 0;
      while (edges == 0 && guard < 4) begin
         @(posedge clk);
         @(negedge clk);
         guard++;
         if (busy_o) edges = 1;
      end
      chk({nm, " accept"}, busy_o, 1'b1);
      stall_ok = 1'b1;
      while (!done_o && edges < 200) begin
         if (stall_o !== start_i) stall_ok = 1'b0;
         if (edges == 1) begin
            rs1_data_i = $urandom;
            rs2_data_i = $urandom;
            funct3_i   = 3'($urandom);
         end
         if (edges == 6 && v.drop) start_i = 1'b0;
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
      exp = sb_q.pop_front();
      chk({nm, " done"}, done_o, 1'b1);
      chk({nm, " latency"}, edges, v.lat);
      chk({nm, " stall busy"}, stall_ok, 1'b1);
      chk({nm, " stall at done"}, stall_o, 1'b0);
      chk({nm, " result"}, result_o, exp);
      start_i = v.keep;
      @(posedge clk);
      @(negedge clk);
      chk({nm, " pulse end"}, done_o, 1'b0);
      chk({nm, " idle after"}, busy_o, 1'b0);
      chk({nm, " result held"}, result_o, exp);
   endtask

   initial begin
      vec_t tbl[14];
      vec_t v;
      int   edges;
      int   guard;
      bit   spurious;

      tbl[0]  = '{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, LAT_FULL, 1'b0, 1'b1};
      tbl[1]  = '{3'b001, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, LAT_FULL, 1'b0, 1'b1};
      tbl[2]  = '{3'b010, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, LAT_FULL, 1'b0, 1'b1};
      tbl[3]  = '{3'b011, 32'h80000000,  32'hFFFFFFFF, 32'h7FFFFFFF, LAT_FULL, 1'b0, 1'b0};
      tbl[4]  = '{3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, LAT_FULL, 1'b0, 1'b1};
      tbl[5]  = '{3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, LAT_FULL, 1'b0, 1'b0};
      tbl[6]  = '{3'b101, 32'd100,       32'd7,        32'd14,       LAT_FULL, 1'b1, 1'b0};
      tbl[7]  = '{3'b111, 32'd100,       32'd7,        32'd2,        LAT_FULL, 1'b0, 1'b1};
      tbl[8]  = '{3'b100, 32'd5,         32'd0,        32'hFFFFFFFF, LAT_DZ,   1'b0, 1'b1};
      tbl[9]  = '{3'b111, 32'd5,         32'd0,        32'd5,        LAT_DZ,   1'b0, 1'b0};
      tbl[10] = '{3'b110, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFB, LAT_DZ,   1'b0, 1'b0};
      tbl[11] = '{3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, LAT_FULL, 1'b0, 1'b1};
      tbl[12] = '{3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, LAT_FULL, 1'b0, 1'b0};
      tbl[13] = '{3'b000, 32'd0,         32'd9,        32'h00000000, LAT_MZ,   1'b0, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset busy", busy_o, 1'b0);
      chk("reset done", done_o, 1'b0);
      chk("reset result", result_o, 32'h0);
      chk("reset stall", stall_o, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         run_op(tbl[i], $sformatf("vec%0d", i));
      end

      // Random operations against a native-arithmetic reference
      for (int i = 0; i < 8; i++) begin
         v.f    = 3'($urandom_range(0, 7));
         v.a    = $urandom;
         v.b    = (i == 3) ? 32'd0 : $urandom;
         v.res  = ref_model(v.f, v.a, v.b);
         v.lat  = ref_lat(v.f, v.a, v.b);
         v.drop = 1'b0;
         v.keep = 1'(i % 2);
         run_op(v, $sformatf("rand%0d f=%0d", i, v.f));
      end

      // Ensure a nonzero held result, then abort a multiply with reset mid-RUN
      run_op(tbl[3], "pre-abort");
      funct3_i   = 3'b000;
      rs1_data_i = 32'd3;
      rs2_data_i = 32'd5;
      start_i    = 1'b1;
      edges = 0;
      guard = 0;
      while (edges == 0 && guard < 4) begin
         @(posedge clk);
         @(negedge clk);
         guard++;
         if (busy_o) edges = 1;
      end
      chk("abort accept", busy_o, 1'b1);
      while (edges < 10) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
      #1 reset = 1'b1;
      #1;
      chk("abort busy", busy_o, 1'b0);
      chk("abort done", done_o, 1'b0);
      chk("abort result", result_o, 32'h0);
      start_i = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      spurious = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done_o || busy_o) spurious = 1'b1;
      end
      chk("abort no done", spurious, 1'b0);
      v = '{3'b001, 32'h12345678, 32'h9ABCDEF0, 32'h0, LAT_FULL, 1'b0, 1'b0};
      v.res = ref_model(v.f, v.a, v.b);
      run_op(v, "post-abort MULH");

      chk("scoreboard empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
